pc_fetch_stage: RTL and testbench
=================================

// Module: pc_fetch_stage
// PURPOSE
//  Consumer of the next-PC selection: owns the 6-bit program counter, drives the
//  instruction-memory address, and registers the IF/ID pipeline latch.
//  Accepts the selected next address plus the branch-taken (PCsrc) flag,
//  applies hazard-unit stalls, and squashes the wrong-path instruction on a taken branch.
// PARAMETERS
//  PC_W        6       program counter / address width
//  INSTR_W     16      instruction word width
//  NOP_WORD    16'h0   value loaded into IF/ID instr on flush/reset
//  HALT_OPCODE 4'hF    instr[INSTR_W-1 -: 4] value treated as HALT (FETCH_HALT_EN only)
// PORTS
//  clk             in   1        single clock, all state on rising edge
//  rst_n           in   1        synchronous, active-low reset
//  in_next_pc      in   PC_W     next address from next-PC mux
//  cntrl_pc_src    in   1        1 = branch taken this cycle (flush request)
//  in_stall        in   1        1 = hazard unit holds PC and IF/ID
//  in_instr        in   INSTR_W  imem read data for out_imem_addr (combinational read)
//  out_imem_addr   out  PC_W     current PC, to imem and adder1
//  out_ifid_pc     out  PC_W     PC of instruction held in IF/ID
//  out_ifid_instr  out  INSTR_W  instruction held in IF/ID
//  out_ifid_valid  out  1        IF/ID holds a real (non-bubble) instruction
//  out_halted      out  1        fetch stopped (constant 0 without FETCH_HALT_EN)
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): PC=0, ifid_pc=0, ifid_instr=NOP_WORD,
//    ifid_valid=0, out_halted=0, state=BOOT. Reset mid-operation discards all state.
//  - FSM: BOOT -> RUN (unconditional, next cycle); RUN -> HALTED (FETCH_HALT_EN only);
//    HALTED exits only via reset. BOOT: PC held at 0, IF/ID stays bubble
//    (one-cycle imem settle); first valid IF/ID appears 2 cycles after reset release.
//  - RUN, per posedge, priority flush > stall > advance:
//    * flush (cntrl_pc_src=1): PC<=in_next_pc; ifid_instr<=NOP_WORD; ifid_valid<=0;
//      ifid_pc<=0. Flush overrides a simultaneous stall.
//    * stall (in_stall=1, no flush): PC and all IF/ID outputs hold.
//    * advance: PC<=in_next_pc; ifid_instr<=in_instr; ifid_pc<=PC; ifid_valid<=1.
//  - Latency: in_instr at address A appears on out_ifid_instr one cycle after PC==A.
//  - Address arithmetic is external; in_next_pc taken verbatim, 63->0 wrap is legal.
//  - Inputs sampled only at posedge; no combinational path input->output
//    except none (all outputs registered).
// CONFIGURATION
//  FETCH_HALT_EN defined: in RUN, advance cycle with in_instr opcode==HALT_OPCODE
//    latches HALT into IF/ID (valid=1), then state->HALTED: PC frozen, further
//    cycles load bubbles (valid=0), out_halted=1. Flush in same cycle wins (no halt).
//  FETCH_HALT_EN undefined: no HALTED state, HALT_OPCODE ignored, out_halted tied 0.
// TESTING
//  1 Reset: rst_n=0 two cycles -> PC=0, ifid_valid=0, ifid_instr=NOP_WORD; release
//    -> BOOT 1 cycle, next_pc=1 -> PC=1, ifid_pc=0 valid=1 on following edge.
//  2 Sequential: next_pc=PC+1, imem[k]=16'h1000+k -> ifid_instr steps 1000,1001,...
//    ifid_pc lags PC by 1; PC=63,next_pc=0 -> PC wraps to 0 cleanly.
//  3 Stall: in_stall=1 for 3 cycles at PC=5 -> PC=5, ifid_pc=4 held; release -> resume 6.
//  4 Branch: PC=8, cntrl_pc_src=1, next_pc=20 -> PC=20, ifid_valid=0 next cycle;
//    stall+flush same cycle -> flush wins, PC=20.
//  5 Reset mid-run: PC=12, rst_n=0 one cycle -> PC=0, valid=0, state BOOT.
//  6 FETCH_HALT_EN: imem[3]=16'hF000 -> ifid_instr=F000 valid=1, then out_halted=1,
//    PC frozen at 4, valid=0 thereafter; without macro PC advances to 4,5,...

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Fetch stage: owns the PC, drives the imem address and registers the IF/ID latch.
// Latency 1 cycle (PC==A -> IF/ID holds imem[A]); flush > stall > advance; optional halt via FETCH_HALT_EN.
// Backpressure: in_stall freezes PC and IF/ID; cntrl_pc_src squashes the fetched word into a bubble.
module pc_fetch_stage #(
    parameter int              PC_W        = 6,
    parameter int              INSTR_W     = 16,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0,
    parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    in_next_pc,
    input  logic               cntrl_pc_src,
    input  logic               in_stall,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [PC_W-1:0]    out_imem_addr,
    output logic [PC_W-1:0]    out_ifid_pc,
    output logic [INSTR_W-1:0] out_ifid_instr,
    output logic               out_ifid_valid,
    output logic               out_halted
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               halted_q, halted_d;
    logic               halt_en;
    logic               opcode_is_halt;

`ifdef FETCH_HALT_EN
    assign halt_en = 1'b1;
`else
    assign halt_en = 1'b0;
`endif

    assign opcode_is_halt = (in_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        halted_d     = halted_q;
        case (state_q)
            // One idle cycle after reset lets the imem read of address 0 settle.
            BOOT: state_d = RUN;
            RUN: begin
                if (cntrl_pc_src) begin
                    pc_d         = in_next_pc;
                    ifid_pc_d    = '0;
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                end else if (!in_stall) begin
                    pc_d         = in_next_pc;
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = in_instr;
                    ifid_valid_d = 1'b1;
                    if (halt_en && opcode_is_halt) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end
                end
            end
            HALTED: begin
                ifid_pc_d    = '0;
                ifid_instr_d = NOP_WORD;
                ifid_valid_d = 1'b0;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_WORD;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign out_imem_addr  = pc_q;
    assign out_ifid_pc    = ifid_pc_q;
    assign out_ifid_instr = ifid_instr_q;
    assign out_ifid_valid = ifid_valid_q;
    assign out_halted     = halted_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios plus random traffic against a cycle-level reference model.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  in_next_pc;
    logic        cntrl_pc_src;
    logic        in_stall;
    logic [15:0] in_instr;
    logic [5:0]  out_imem_addr;
    logic [5:0]  out_ifid_pc;
    logic [15:0] out_ifid_instr;
    logic        out_ifid_valid;
    logic        out_halted;

    logic [15:0] imem [64];

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_pc, m_ipc, m_instr, m_valid, m_halted, m_boot;

    always #5 clk = ~clk;

    assign in_instr = imem[out_imem_addr];

    pc_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .in_next_pc(in_next_pc), .cntrl_pc_src(cntrl_pc_src),
        .in_stall(in_stall), .in_instr(in_instr), .out_imem_addr(out_imem_addr),
        .out_ifid_pc(out_ifid_pc), .out_ifid_instr(out_ifid_instr),
        .out_ifid_valid(out_ifid_valid), .out_halted(out_halted)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pc", out_imem_addr, m_pc);
        chk("ifid_pc", out_ifid_pc, m_ipc);
        chk("ifid_instr", out_ifid_instr, m_instr);
        chk("ifid_valid", out_ifid_valid, m_valid);
        chk("halted", out_halted, m_halted);
    endtask

    // Drive one cycle's inputs (called at negedge), advance the model, check after the edge.
    task automatic step(input logic rst, input int npc, input logic stall, input logic flush);
        rst_n = rst; in_next_pc = npc[5:0]; in_stall = stall; cntrl_pc_src = flush;
        if (!rst) begin
            m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0; m_boot = 1;
        end else if (m_boot == 1) begin
            m_boot = 0;
        end else if (m_halted == 1 || flush) begin
            if (flush && m_halted == 0) m_pc = npc % 64;
            m_ipc = 0; m_instr = 0; m_valid = 0;
        end else if (!stall) begin
            m_ipc   = m_pc;
            m_instr = imem[m_pc];
            m_valid = 1;
            m_pc    = npc % 64;
`ifdef FETCH_HALT_EN
            if (m_instr / 4096 == 15) m_halted = 1;
`endif
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b1, m_pc + 1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_next_pc = '0; cntrl_pc_src = 1'b0; in_stall = 1'b0;
        for (int k = 0; k < 64; k++) imem[k] = 16'h1000 + 16'(k);
        m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0; m_boot = 1;
        @(negedge clk);

        // reset, boot cycle, first valid fetch
        do_reset();
        chk("rst_pc", out_imem_addr, 0);
        chk("rst_valid", out_ifid_valid, 0);
        chk("rst_instr", out_ifid_instr, 0);
        step(1'b1, 1, 1'b0, 1'b0);
        chk("boot_pc_held", out_imem_addr, 0);
        chk("boot_bubble", out_ifid_valid, 0);
        step(1'b1, 1, 1'b0, 1'b0);
        chk("first_pc", out_imem_addr, 1);
        chk("first_ifid_pc", out_ifid_pc, 0);
        chk("first_valid", out_ifid_valid, 1);
        chk("first_instr", out_ifid_instr, 16'h1000);

        // sequential run through the 63 -> 0 wrap
        seq(62);
        chk("at63", out_imem_addr, 63);
        chk("instr62", out_ifid_instr, 16'h103E);
        seq(1);
        chk("wrap_pc", out_imem_addr, 0);
        chk("wrap_ifid_pc", out_ifid_pc, 63);
        chk("wrap_instr", out_ifid_instr, 16'h103F);

        // stall at PC=5
        do_reset();
        seq(6);
        chk("pre_stall_pc", out_imem_addr, 5);
        for (int i = 0; i < 3; i++) step(1'b1, 6, 1'b1, 1'b0);
        chk("stall_pc", out_imem_addr, 5);
        chk("stall_ifid_pc", out_ifid_pc, 4);
        chk("stall_instr", out_ifid_instr, 16'h1004);
        seq(1);
        chk("resume_pc", out_imem_addr, 6);
        chk("resume_ifid_pc", out_ifid_pc, 5);

        // taken branch at PC=8, then flush racing a stall
        seq(2);
        chk("br_pc8", out_imem_addr, 8);
        step(1'b1, 20, 1'b0, 1'b1);
        chk("br_pc", out_imem_addr, 20);
        chk("br_valid", out_ifid_valid, 0);
        chk("br_ifid_pc", out_ifid_pc, 0);
        step(1'b1, 40, 1'b1, 1'b1);
        chk("flush_over_stall", out_imem_addr, 40);
        chk("flush_over_stall_v", out_ifid_valid, 0);

        // reset mid-run
        do_reset();
        seq(13);
        chk("mid_pc12", out_imem_addr, 12);
        step(1'b0, 13, 1'b0, 1'b0);
        chk("mid_rst_pc", out_imem_addr, 0);
        chk("mid_rst_valid", out_ifid_valid, 0);
        step(1'b1, 1, 1'b0, 1'b0);
        chk("mid_rst_boot", out_imem_addr, 0);

        // halt opcode at address 3
        imem[3] = 16'hF000;
        do_reset();
        seq(5);
        chk("halt_instr", out_ifid_instr, 16'hF000);
        chk("halt_latched_v", out_ifid_valid, 1);
        seq(2);
`ifdef FETCH_HALT_EN
        chk("halt_pc_frozen", out_imem_addr, 4);
        chk("halt_bubble", out_ifid_valid, 0);
        chk("halt_flag", out_halted, 1);
`else
        chk("nohalt_pc", out_imem_addr, 6);
        chk("nohalt_valid", out_ifid_valid, 1);
        chk("nohalt_flag", out_halted, 0);
`endif

        // random traffic; keep HALT opcodes out of imem so halts stay rare
        for (int k = 0; k < 64; k++) begin
            imem[k] = 16'($urandom);
            if (imem[k][15:12] == 4'hF) imem[k][15] = 1'b0;
        end
        imem[$urandom_range(63)] = 16'hF123;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic r, s, f;
            int   n;
            r = ($urandom_range(99) >= 3);
            s = ($urandom_range(99) < 20);
            f = ($urandom_range(99) < 15);
            n = ($urandom_range(99) < 70) ? m_pc + 1 : int'($urandom_range(63));
            step(r, n, s, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
